mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one shift-add multiplier (MD, MR, init, clk -> pp, done) between N_REQ requesters.
//  Round-robin arbitration picks a requester and latches its operands.
//  The block then pulses the multiplier's init, waits for done and returns pp with a one-cycle ack.
//  A watchdog stops a lost done from hanging the shared resource.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  W        3   operand width; product width is 2*W
//  TIMEOUT  64  max cycles in WAIT before the operation is aborted with err
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-low reset (0 = reset)
//  req         in   N_REQ      request per requester; held high until its ack
//  md_in       in   N_REQ*W    multiplicands; slice i = md_in[i*W +: W]
//  mr_in       in   N_REQ*W    multipliers; slice i = mr_in[i*W +: W]
//  ack         out  N_REQ      one-cycle completion pulse for the granted requester
//  result      out  2*W        product of the last completed operation
//  err         out  1          high together with ack when the operation timed out
//  busy        out  1          high in any state other than IDLE
//  grant_id    out  clog2(N)   index of the requester being served
//  mult_md     out  W          to multiplier MD
//  mult_mr     out  W          to multiplier MR
//  mult_init   out  1          to multiplier init
//  mult_done   in   1          from multiplier done
//  mult_pp     in   2*W        from multiplier pp
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rr_ptr=0.
//   ack, result, err, busy, grant_id, mult_md, mult_mr and mult_init all reset to 0.
//   done_q=0.
//  All outputs are registered.
//  FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - If req!=0, pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
//   - Latch grant_id and that requester's md/mr into mult_md/mult_mr.
//   - Set busy=1 and go to START.
//  START:
//   - mult_init=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
//  WAIT:
//   - mult_init=0. Operands stay stable on mult_md/mult_mr.
//   - Completion is a rising edge of mult_done (mult_done=1 and done_q=0).
//     A done level left high from a prior operation is never accepted.
//   - On completion: result<=mult_pp, err<=0, go to RESP.
//   - If the counter reaches TIMEOUT-1 with no edge: result<=0, err<=1, go to RESP.
//  RESP:
//   - ack[grant_id]=1 and all other ack bits 0, for this cycle only.
//   - rr_ptr<=(grant_id+1) mod N_REQ; busy=0 on exit; go to IDLE.
//   - result and err hold until the next RESP.
//  Latency:
//   - req seen in IDLE at cycle 0; init is high at cycle 1.
//   - ack comes 1 cycle after the captured done edge.
//   - There is at least one IDLE cycle between operations.
//  Requester rules:
//   - A requester may re-raise req in the same cycle as its ack.
//     It is evaluated at the next IDLE, at lowest priority.
//   - Dropping req mid-operation does not abort; ack is still pulsed.
//   - md/mr changes after grant are ignored.
//  Reset mid-operation: immediate return to IDLE; no ack is issued; the operation is lost.
//  done_q <= mult_done every cycle in all states.
// TESTING
//  1. Single req[0], md0=4, mr0=3:
//     -> mult_init pulse 1 cycle; ack=4'b0001 with result=12, err=0.
//  2. req=4'b1111, slice i: md=i+1, mr=7, held after ack:
//     -> ack order 0,1,2,3,0; results 7,14,21,28.
//  3. md=7, mr=7 on req[2] while req[1] is also pending, rr_ptr=2:
//     -> req[2] served first, result=49; then req[1].
//  4. mult_done held high before START:
//     -> not accepted; only a later low->high edge completes.
//  5. Model never raises done, TIMEOUT=64:
//     -> ack after 64 WAIT cycles with err=1, result=0; next request served normally.
//  6. rst=0 asserted in WAIT:
//     -> all outputs 0 asynchronously, no ack; after release a new req completes correctly.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared shift-add multiplier.
// The slave modport is the arbiter's view. The master modport is the environment's view
// (requesters plus multiplier).
interface mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 3
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] md_in;
    logic [N_REQ*W-1:0] mr_in;
    logic [N_REQ-1:0]   ack;
    logic [2*W-1:0]     result;
    logic               err;
    logic               busy;
    logic [GW-1:0]      grant_id;
    logic [W-1:0]       mult_md;
    logic [W-1:0]       mult_mr;
    logic               mult_init;
    logic               mult_done;
    logic [2*W-1:0]     mult_pp;

    modport slave (
        input  req, md_in, mr_in, mult_done, mult_pp,
        output ack, result, err, busy, grant_id, mult_md, mult_mr, mult_init
    );

    modport master (
        output req, md_in, mr_in, mult_done, mult_pp,
        input  ack, result, err, busy, grant_id, mult_md, mult_mr, mult_init
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that time-shares one shift-add multiplier between N_REQ requesters.
// It latches the winner's operands, pulses init and waits for a rising edge of done.
// It then returns the product with a one-cycle ack.
// A watchdog aborts a WAIT that never sees done and reports it through err.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic [GW-1:0]    r_rr_ptr;
    logic [GW-1:0]    r_grant_id;
    logic [CW-1:0]    r_cnt;
    logic             r_done_q;
    logic [N_REQ-1:0] r_ack;
    logic [2*W-1:0]   r_result;
    logic             r_err;
    logic             r_busy;
    logic             r_init;
    logic [W-1:0]     r_md;
    logic [W-1:0]     r_mr;

    int               w_idx;
    logic             w_found;
    logic [GW-1:0]    w_pick;
    logic [W-1:0]     w_pick_md;
    logic [W-1:0]     w_pick_mr;
    logic             w_done_edge;
    logic [N_REQ-1:0] w_ack_onehot;
    logic [GW-1:0]    w_next_ptr;

    // Pick the first pending request at or after rr_ptr, wrapping around.
    always_comb begin
        w_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    // One-hot ack for the requester currently being served.
    always_comb begin
        w_ack_onehot             = '0;
        w_ack_onehot[r_grant_id] = 1'b1;
    end

    assign w_pick_md   = bus.md_in[int'(w_pick)*W +: W];
    assign w_pick_mr   = bus.mr_in[int'(w_pick)*W +: W];
    // Only a fresh low->high transition counts; a done level left over from an earlier operation is ignored.
    assign w_done_edge = bus.mult_done & ~r_done_q;
    assign w_next_ptr  = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + GW'(1);

    // Main FSM: IDLE -> START -> WAIT -> RESP, all outputs registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_done_q   <= 1'b0;
            r_ack      <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_init     <= 1'b0;
            r_md       <= '0;
            r_mr       <= '0;
        end else begin
            r_done_q <= bus.mult_done;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_md       <= w_pick_md;
                        r_mr       <= w_pick_mr;
                        r_busy     <= 1'b1;
                        // Raised here so that init is visible during the START cycle.
                        r_init     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_init  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_edge) begin
                        r_result <= bus.mult_pp;
                        r_err    <= 1'b0;
                        r_ack    <= w_ack_onehot;
                        r_state  <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_ack    <= w_ack_onehot;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_ack    <= '0;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.result    = r_result;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant_id;
    assign bus.mult_md   = r_md;
    assign bus.mult_mr   = r_mr;
    assign bus.mult_init = r_init;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed testbench for mult_arbiter: behavioural multiplier model plus scenario tasks.
module tb_mult_arbiter;
    localparam int LAT = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic       manual;
    logic       man_done;
    logic [5:0] man_pp;
    logic       m_done;
    logic [5:0] m_pp;
    logic       model_dead;
    logic       pend;
    int         m_cnt;

    mult_arbiter_if #(.N_REQ(4), .W(3)) bus ();

    mult_arbiter #(.N_REQ(4), .W(3), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mult_done = manual ? man_done : m_done;
    assign bus.mult_pp   = manual ? man_pp   : m_pp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift-add multiplier stand-in: done rises LAT+1 cycles after init and holds until the next init.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_done <= 1'b0;
            m_pp   <= '0;
            pend   <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.mult_init) begin
            m_done <= 1'b0;
            pend   <= 1'b1;
            m_cnt  <= LAT;
        end else if (pend && !model_dead) begin
            if (m_cnt == 0) begin
                m_done <= 1'b1;
                m_pp   <= 6'(bus.mult_md) * 6'(bus.mult_mr);
                pend   <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ack(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.ack != 4'b0000) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus.req    = '0;
        bus.md_in  = '0;
        bus.mr_in  = '0;
        manual     = 1'b0;
        man_done   = 1'b0;
        man_pp     = '0;
        model_dead = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL rst_ack: got %b expected 0000", bus.ack); end
        checks++; if (bus.result !== 6'd0) begin failures++; $display("FAIL rst_result: got %0d expected 0", bus.result); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.mult_init !== 1'b0) begin failures++; $display("FAIL rst_init: got %b expected 0", bus.mult_init); end
        checks++; if ({bus.mult_md, bus.mult_mr} !== 6'd0) begin failures++; $display("FAIL rst_operands: got %0d/%0d expected 0/0", bus.mult_md, bus.mult_mr); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single();
        int n;
        bit seen;
        bus.md_in = {3'd0, 3'd0, 3'd0, 3'd4};
        bus.mr_in = {3'd0, 3'd0, 3'd0, 3'd3};
        bus.req   = 4'b0001;
        @(negedge clk);
        checks++; if (bus.mult_init !== 1'b1) begin failures++; $display("FAIL t1_init_high: got %b expected 1", bus.mult_init); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t1_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL t1_grant: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.mult_md !== 3'd4 || bus.mult_mr !== 3'd3) begin failures++; $display("FAIL t1_operands: got %0d/%0d expected 4/3", bus.mult_md, bus.mult_mr); end
        @(negedge clk);
        checks++; if (bus.mult_init !== 1'b0) begin failures++; $display("FAIL t1_init_pulse: got %b expected 0", bus.mult_init); end
        wait_ack(100, n, seen);
        checks++; if (!seen) begin failures++; $display("FAIL t1_timeout: no ack within %0d cycles", n); end
        checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL t1_ack: got %b expected 0001", bus.ack); end
        checks++; if (bus.result !== 6'd12) begin failures++; $display("FAIL t1_result: got %0d expected 12", bus.result); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL t1_err: got %b expected 0", bus.err); end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL t1_ack_once: got %b expected 0000", bus.ack); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t1_busy_clear: got %b expected 0", bus.busy); end
        repeat (3) @(negedge clk);
        checks++; if (bus.result !== 6'd12) begin failures++; $display("FAIL t1_result_hold: got %0d expected 12", bus.result); end
    endtask

    task automatic test_round_robin();
        int n;
        bit seen;
        logic [3:0] exp_ack [5];
        int         exp_res [5];
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_res = '{7, 14, 21, 28, 7};
        do_reset();
        bus.md_in = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.mr_in = {3'd7, 3'd7, 3'd7, 3'd7};
        bus.req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(100, n, seen);
            checks++; if (bus.ack !== exp_ack[i]) begin failures++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, bus.ack, exp_ack[i]); end
            checks++; if (bus.result !== 6'(exp_res[i])) begin failures++; $display("FAIL rr_result[%0d]: got %0d expected %0d", i, bus.result, exp_res[i]); end
            if (i == 4) bus.req = 4'b0000;
            @(negedge clk);
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_idle_gap[%0d]: busy got %b expected 0", i, bus.busy); end
        end
    endtask

    task automatic test_priority();
        int n;
        bit seen;
        bus.md_in = {3'd0, 3'd0, 3'd2, 3'd0};
        bus.mr_in = {3'd0, 3'd0, 3'd3, 3'd0};
        bus.req   = 4'b0010;
        wait_ack(100, n, seen);
        checks++; if (bus.ack !== 4'b0010 || bus.result !== 6'd6) begin failures++; $display("FAIL pri_setup: got ack %b result %0d expected 0010/6", bus.ack, bus.result); end
        bus.req = 4'b0000;
        @(negedge clk);
        bus.md_in = {3'd0, 3'd7, 3'd5, 3'd0};
        bus.mr_in = {3'd0, 3'd7, 3'd2, 3'd0};
        bus.req   = 4'b0110;
        @(negedge clk);
        checks++; if (bus.grant_id !== 2'd2) begin failures++; $display("FAIL pri_grant: got %0d expected 2", bus.grant_id); end
        bus.md_in = {3'd0, 3'd1, 3'd5, 3'd0};
        wait_ack(100, n, seen);
        checks++; if (bus.ack !== 4'b0100) begin failures++; $display("FAIL pri_ack2: got %b expected 0100", bus.ack); end
        checks++; if (bus.result !== 6'd49) begin failures++; $display("FAIL pri_result49: got %0d expected 49", bus.result); end
        bus.req = 4'b0010;
        wait_ack(100, n, seen);
        checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL pri_ack1: got %b expected 0010", bus.ack); end
        checks++; if (bus.result !== 6'd10) begin failures++; $display("FAIL pri_result10: got %0d expected 10", bus.result); end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_stale_done();
        bit ok;
        manual    = 1'b1;
        man_done  = 1'b1;
        man_pp    = 6'd63;
        bus.md_in = {3'd3, 3'd0, 3'd0, 3'd0};
        bus.mr_in = {3'd3, 3'd0, 3'd0, 3'd0};
        bus.req   = 4'b1000;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000 || bus.busy !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL stale_level: got ack %b busy %b expected 0000/1", bus.ack, bus.busy); end
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL stale_low: got %b expected 0000", bus.ack); end
        man_pp   = 6'd9;
        man_done = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b1000) begin failures++; $display("FAIL stale_edge_ack: got %b expected 1000", bus.ack); end
        checks++; if (bus.result !== 6'd9) begin failures++; $display("FAIL stale_result: got %0d expected 9", bus.result); end
        bus.req  = 4'b0000;
        man_done = 1'b0;
        manual   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        model_dead = 1'b1;
        bus.md_in  = {3'd0, 3'd0, 3'd0, 3'd2};
        bus.mr_in  = {3'd0, 3'd0, 3'd0, 3'd2};
        bus.req    = 4'b0001;
        wait_ack(200, n, seen);
        checks++; if (!seen || n != 66) begin failures++; $display("FAIL to_latency: got ack after %0d cycles expected 66", n); end
        checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL to_ack: got %b expected 0001", bus.ack); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err: got %b expected 1", bus.err); end
        checks++; if (bus.result !== 6'd0) begin failures++; $display("FAIL to_result: got %0d expected 0", bus.result); end
        bus.req    = 4'b0000;
        model_dead = 1'b0;
        @(negedge clk);
        bus.md_in = {3'd0, 3'd0, 3'd5, 3'd0};
        bus.mr_in = {3'd0, 3'd0, 3'd5, 3'd0};
        bus.req   = 4'b0010;
        wait_ack(100, n, seen);
        checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL to_next_ack: got %b expected 0010", bus.ack); end
        checks++; if (bus.result !== 6'd25 || bus.err !== 1'b0) begin failures++; $display("FAIL to_next_result: got %0d err %b expected 25 err 0", bus.result, bus.err); end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        model_dead = 1'b1;
        bus.md_in  = {3'd0, 3'd6, 3'd0, 3'd0};
        bus.mr_in  = {3'd0, 3'd6, 3'd0, 3'd0};
        bus.req    = 4'b0100;
        repeat (5) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin failures++; $display("FAIL rm_pre: got busy %b grant %0d expected 1/2", bus.busy, bus.grant_id); end
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.grant_id !== 2'd0 || bus.mult_md !== 3'd0 || bus.mult_mr !== 3'd0) begin failures++; $display("FAIL rm_regs: got grant %0d md %0d mr %0d expected 0", bus.grant_id, bus.mult_md, bus.mult_mr); end
        checks++; if (bus.result !== 6'd0 || bus.err !== 1'b0) begin failures++; $display("FAIL rm_result: got %0d err %b expected 0/0", bus.result, bus.err); end
        checks++; if (bus.ack !== 4'b0000 || bus.mult_init !== 1'b0) begin failures++; $display("FAIL rm_ack_init: got %b/%b expected 0000/0", bus.ack, bus.mult_init); end
        bus.req = 4'b0000;
        @(negedge clk);
        rst        = 1'b1;
        model_dead = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_no_ack: got ack %b busy %b expected 0000/0", bus.ack, bus.busy); end
        bus.md_in = {3'd7, 3'd0, 3'd0, 3'd0};
        bus.mr_in = {3'd6, 3'd0, 3'd0, 3'd0};
        bus.req   = 4'b1000;
        wait_ack(100, n, seen);
        checks++; if (bus.ack !== 4'b1000) begin failures++; $display("FAIL rm_after_ack: got %b expected 1000", bus.ack); end
        checks++; if (bus.result !== 6'd42 || bus.err !== 1'b0) begin failures++; $display("FAIL rm_after_result: got %0d err %b expected 42 err 0", bus.result, bus.err); end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_stale_done();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
